// File: rtl/count_seq_checker.sv
// Step checker for an up/down counter: locks after SYNC_LEN good steps, then flags
// mismatches, wraps and direction changes and keeps saturating statistics.
module count_seq_checker #(
  parameter int WIDTH    = 3,
  parameter int SYNC_LEN = 2,
  parameter int STAT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr_stats,
  input  logic              down,
  input  logic [WIDTH-1:0]  count,
  output logic              locked,
  output logic              err_pulse,
  output logic              wrap_pulse,
  output logic              dir_pulse,
  output logic [STAT_W-1:0] err_count,
  output logic [STAT_W-1:0] wrap_up_count,
  output logic [STAT_W-1:0] wrap_dn_count
);

  // state     | meaning
  // ST_IDLE   | disabled, prev not tracked
  // ST_ACQ    | counting consecutive correct steps toward lock
  // ST_LOCKED | sequence trusted; mismatches, wraps and direction changes reported
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACQ    = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [WIDTH-1:0]  CNT_MAX  = '1;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;
  localparam logic [3:0]        SYNC_TGT = 4'(SYNC_LEN);

  logic [1:0]       state;
  logic [WIDTH-1:0] prev_count;
  logic             prev_down;
  logic [3:0]       match_cnt;
  logic [WIDTH-1:0] expected;
  logic             step_ok;
  logic             wrap_up_ev;
  logic             wrap_dn_ev;

  assign expected   = prev_down ? (prev_count - 1'b1) : (prev_count + 1'b1);
  assign step_ok    = (count == expected);
  assign wrap_up_ev = step_ok && !prev_down && (prev_count == CNT_MAX) && (count == '0);
  assign wrap_dn_ev = step_ok && prev_down && (prev_count == '0) && (count == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      prev_count    <= '0;
      prev_down     <= 1'b0;
      match_cnt     <= '0;
      locked        <= 1'b0;
      err_pulse     <= 1'b0;
      wrap_pulse    <= 1'b0;
      dir_pulse     <= 1'b0;
      err_count     <= '0;
      wrap_up_count <= '0;
      wrap_dn_count <= '0;
    end else begin
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
      dir_pulse  <= 1'b0;
      if (clr_stats) begin
        err_count     <= '0;
        wrap_up_count <= '0;
        wrap_dn_count <= '0;
      end
      if (!en) begin
        state     <= ST_IDLE;
        match_cnt <= '0;
        locked    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            state      <= ST_ACQ;
            prev_count <= count;
            prev_down  <= down;
            match_cnt  <= '0;
          end
          ST_ACQ: begin
            prev_count <= count;
            prev_down  <= down;
            if (step_ok) begin
              if (match_cnt + 4'd1 >= SYNC_TGT) begin
                state     <= ST_LOCKED;
                locked    <= 1'b1;
                match_cnt <= '0;
              end else begin
                match_cnt <= match_cnt + 4'd1;
              end
            end else begin
              match_cnt <= '0;
            end
          end
          ST_LOCKED: begin
            prev_count <= count;
            prev_down  <= down;
            // direction only affects the next step, so it is reported regardless of step_ok
            dir_pulse  <= (down != prev_down);
            if (!step_ok) begin
              err_pulse <= 1'b1;
              state     <= ST_ACQ;
              locked    <= 1'b0;
              match_cnt <= '0;
              if (!clr_stats && err_count != STAT_MAX) err_count <= err_count + 1'b1;
            end else if (wrap_up_ev) begin
              wrap_pulse <= 1'b1;
              if (!clr_stats && wrap_up_count != STAT_MAX) wrap_up_count <= wrap_up_count + 1'b1;
            end else if (wrap_dn_ev) begin
              wrap_pulse <= 1'b1;
              if (!clr_stats && wrap_dn_count != STAT_MAX) wrap_dn_count <= wrap_dn_count + 1'b1;
            end
          end
          default: begin
            state     <= ST_IDLE;
            match_cnt <= '0;
            locked    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_count_seq_checker.sv
// Scoreboard bench for count_seq_checker: directed vectors push hand-derived
// expectations; a negedge monitor pops and compares them one cycle later.
module tb_count_seq_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       clr_stats = 1'b0;
  logic       down = 1'b0;
  logic [2:0] count = 3'd0;
  logic       locked, err_pulse, wrap_pulse, dir_pulse;
  logic [7:0] err_count, wrap_up_count, wrap_dn_count;

  count_seq_checker #(.WIDTH(3), .SYNC_LEN(2), .STAT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .clr_stats(clr_stats), .down(down), .count(count),
    .locked(locked), .err_pulse(err_pulse), .wrap_pulse(wrap_pulse), .dir_pulse(dir_pulse),
    .err_count(err_count), .wrap_up_count(wrap_up_count), .wrap_dn_count(wrap_dn_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic       lk, er, wr, dr;
    logic [7:0] ec, wu, wd;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_ec = 0, exp_wu = 0, exp_wd = 0;
  int   x;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && q[0].due < cyc) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL stale_expectation due %0d seen at cycle %0d", e.due, cyc);
    end else if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("locked",        {7'd0, locked},     {7'd0, e.lk});
      chk("err_pulse",     {7'd0, err_pulse},  {7'd0, e.er});
      chk("wrap_pulse",    {7'd0, wrap_pulse}, {7'd0, e.wr});
      chk("dir_pulse",     {7'd0, dir_pulse},  {7'd0, e.dr});
      chk("err_count",     err_count,     e.ec);
      chk("wrap_up_count", wrap_up_count, e.wu);
      chk("wrap_dn_count", wrap_dn_count, e.wd);
    end
  end

  // wr: 0 none, 1 up-wrap, 2 down-wrap
  task automatic v(input logic r, input logic e, input logic c, input logic [2:0] cn,
                   input logic d, input logic lk, input logic er, input int wr, input logic dr);
    exp_t it;
    @(negedge clk);
    rst = r; en = e; clr_stats = c; count = cn; down = d;
    if (r || c) begin
      exp_ec = 0; exp_wu = 0; exp_wd = 0;
    end else begin
      if (er && exp_ec != 8'hFF) exp_ec = exp_ec + 1;
      if (wr == 1 && exp_wu != 8'hFF) exp_wu = exp_wu + 1;
      if (wr == 2 && exp_wd != 8'hFF) exp_wd = exp_wd + 1;
    end
    it.due = cyc + 1;
    it.lk = lk; it.er = er; it.wr = (wr != 0); it.dr = dr;
    it.ec = exp_ec; it.wu = exp_wu; it.wd = exp_wd;
    q.push_back(it);
  endtask

  // From LOCKED with prev=x (up): inject a skip, then two good steps to relock.
  task automatic err_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      x = (x + 3) % 8;
      v(0, 1, 0, 3'(x), 0, 0, 1, 0, 0);
      v(0, 1, 0, 3'((x + 1) % 8), 0, 0, 0, 0, 0);
      v(0, 1, 0, 3'((x + 2) % 8), 0, 1, 0, 0, 0);
      x = (x + 2) % 8;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: reset with en high and count toggling, then lock on an up sequence
    v(1, 1, 0, 3'd0, 0, 0, 0, 0, 0);
    v(1, 1, 0, 3'd5, 1, 0, 0, 0, 0);
    v(0, 1, 0, 3'd0, 0, 0, 0, 0, 0);
    v(0, 1, 0, 3'd1, 0, 0, 0, 0, 0);
    v(0, 1, 0, 3'd2, 0, 1, 0, 0, 0);
    v(0, 1, 0, 3'd3, 0, 1, 0, 0, 0);
    // 2: up wrap, then direction change and down wrap
    v(0, 1, 0, 3'd4, 0, 1, 0, 0, 0);
    v(0, 1, 0, 3'd5, 0, 1, 0, 0, 0);
    v(0, 1, 0, 3'd6, 0, 1, 0, 0, 0);
    v(0, 1, 0, 3'd7, 0, 1, 0, 0, 0);
    v(0, 1, 0, 3'd0, 0, 1, 0, 1, 0);
    v(0, 1, 0, 3'd1, 0, 1, 0, 0, 0);
    v(0, 1, 0, 3'd2, 1, 1, 0, 0, 1);
    v(0, 1, 0, 3'd1, 1, 1, 0, 0, 0);
    v(0, 1, 0, 3'd0, 1, 1, 0, 0, 0);
    v(0, 1, 0, 3'd7, 1, 1, 0, 2, 0);
    // 3: back to up, skip a value, relock
    v(0, 1, 0, 3'd6, 0, 1, 0, 0, 1);
    v(0, 1, 0, 3'd7, 0, 1, 0, 0, 0);
    v(0, 1, 0, 3'd0, 0, 1, 0, 1, 0);
    v(0, 1, 0, 3'd1, 0, 1, 0, 0, 0);
    v(0, 1, 0, 3'd2, 0, 1, 0, 0, 0);
    v(0, 1, 0, 3'd3, 0, 1, 0, 0, 0);
    v(0, 1, 0, 3'd4, 0, 1, 0, 0, 0);
    v(0, 1, 0, 3'd6, 0, 0, 1, 0, 0);
    v(0, 1, 0, 3'd7, 0, 0, 0, 0, 0);
    v(0, 1, 0, 3'd0, 0, 1, 0, 0, 0);
    v(0, 1, 0, 3'd1, 0, 1, 0, 0, 0);
    // 5: disable while a bad sample arrives; re-enable without stale compare
    v(0, 0, 0, 3'd5, 0, 0, 0, 0, 0);
    v(0, 0, 0, 3'd6, 1, 0, 0, 0, 0);
    v(0, 1, 0, 3'd3, 0, 0, 0, 0, 0);
    v(0, 1, 0, 3'd4, 0, 0, 0, 0, 0);
    v(0, 1, 0, 3'd5, 0, 1, 0, 0, 0);
    // 4: drive err_count into saturation, then clear coinciding with a wrap
    x = 5;
    err_cycles(261);
    while (x != 7) begin
      x = x + 1;
      v(0, 1, 0, 3'(x), 0, 1, 0, 0, 0);
    end
    v(0, 1, 1, 3'd0, 0, 1, 0, 1, 0);
    v(0, 1, 0, 3'd1, 0, 1, 0, 0, 0);
    // 6: reset while locked with err_count=3, then resume
    x = 1;
    err_cycles(3);
    v(1, 1, 0, 3'd4, 1, 0, 0, 0, 0);
    v(0, 1, 0, 3'd2, 0, 0, 0, 0, 0);
    v(0, 1, 0, 3'd3, 0, 0, 0, 0, 0);
    v(0, 1, 0, 3'd4, 0, 1, 0, 0, 0);
    v(0, 1, 0, 3'd5, 0, 1, 0, 0, 0);

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
